// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, state types and padding helpers for the SHA-256 front end
//
// Contents:
//   WORD_W, BLOCK_WORDS, LEN_W          : datapath geometry
//   PAD_MARKER                          : the 0x80 marker byte placed in the top byte of a word
//   LEN_HI_IDX / LEN_LO_IDX / LAST_IDX  : fixed word slots at the tail of a block
//   pad_state_e, tail_e                 : padder FSM state and pending follow-on block kind
//   clamp_nbytes, pad_last_word         : final-word byte handling
package sha256_pkg;

   localparam int WORD_W      = 32;
   localparam int BLOCK_WORDS = 16;
   localparam int LEN_W       = 64;

   localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;
   localparam logic [4:0]        LEN_HI_IDX = 5'd14;
   localparam logic [4:0]        LEN_LO_IDX = 5'd15;
   localparam logic [4:0]        LAST_IDX   = 5'd15;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_PAD,
      ST_SEND,
      ST_WAIT
   } pad_state_e;

   // What the block after the current burst has to be built from once the
   // message input has already ended.
   typedef enum logic [1:0] {
      TAIL_NONE,   // more message words follow (or the current block is final)
      TAIL_MARK,   // message ended exactly on a block boundary: marker goes at word 0
      TAIL_ZERO    // marker already sent, no room for the length: zeros + length
   } tail_e;

   // Byte counts above 4 are treated as a full word.
   function automatic logic [2:0] clamp_nbytes(input logic [2:0] nbytes);
      return (nbytes > 3'd4) ? 3'd4 : nbytes;
   endfunction

   // Keeps the valid MSB-aligned bytes of the final word, puts the marker in
   // the first unused byte and clears everything below it.
   function automatic logic [WORD_W-1:0] pad_last_word(input logic [WORD_W-1:0] w,
                                                       input logic [2:0]        nbytes);
      logic [WORD_W-1:0] r;
      case (clamp_nbytes(nbytes))
         3'd0:    r = PAD_MARKER;
         3'd1:    r = {w[31:24], 24'h80_0000};
         3'd2:    r = {w[31:16], 16'h8000};
         3'd3:    r = {w[31:8],  8'h80};
         default: r = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - message input and core write-burst signals of the padder
//
// Signals:
//   in_data/in_valid/in_last/in_nbytes/in_ready : byte-message word stream into the padder
//   busy                                        : core compressing, gates burst start
//   data/write_enable/first_block/last_block    : 16-word block burst towards the core
// Modports:
//   slave  : the padder
//   master : the message source and core side
interface sha256_msg_padder_if;
   import sha256_pkg::*;

   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic [2:0]        in_nbytes;
   logic              in_ready;
   logic              busy;
   logic [WORD_W-1:0] data;
   logic              write_enable;
   logic              first_block;
   logic              last_block;

   modport slave (
      input  in_data, in_valid, in_last, in_nbytes, busy,
      output in_ready, data, write_enable, first_block, last_block
   );

   modport master (
      output in_data, in_valid, in_last, in_nbytes, busy,
      input  in_ready, data, write_enable, first_block, last_block
   );

endinterface

// File: rtl/sha256_block_buffer.sv
// rtl/sha256_block_buffer.sv - 16x32 block register file with one write and one read port
//
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_idx  : write word index
//   wr_data : write word
//   rd_idx  : read word index (send counter)
//   rd_data : combinational read word
module sha256_block_buffer
   import sha256_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [3:0]        wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [3:0]        rd_idx,
   output logic [WORD_W-1:0] rd_data
);

   // Every slot is rewritten before each burst, so the storage needs no reset.
   logic [WORD_W-1:0] mem_q [BLOCK_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - FIPS 180-4 message padder feeding 16-word block bursts to the core
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset; discards any message in flight
//   bus   : sha256_msg_padder_if.slave (message input, busy, block burst output)
module sha256_msg_padder
   import sha256_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   sha256_msg_padder_if.slave bus
);

   pad_state_e        state_q;
   tail_e             tail_q;
   logic [4:0]        wptr_q;
   logic [4:0]        scnt_q;
   logic [LEN_W-1:0]  len_q;
   logic              first_q;     // next burst is the message's first block
   logic              final_q;     // buffered block carries the length
   logic              mark_q;      // marker still to be written at wptr
   logic              fit_q;       // marker landed early enough for the length to fit
   logic              wait_q;
   logic              in_ready_q;
   logic              we_q;
   logic              first_block_q;
   logic              last_block_q;
   logic [WORD_W-1:0] data_q;

   logic              accept;
   logic [2:0]        word_nbytes;
   logic              wr_en;
   logic [WORD_W-1:0] wr_data;
   logic [WORD_W-1:0] rd_data;

   assign accept      = bus.in_valid && in_ready_q;
   assign word_nbytes = bus.in_last ? clamp_nbytes(bus.in_nbytes) : 3'd4;

   // Buffer write port: input words while filling, generated words while padding.
   always_comb begin
      wr_en   = 1'b0;
      wr_data = '0;
      if (accept) begin
         wr_en   = 1'b1;
         wr_data = bus.in_last ? pad_last_word(bus.in_data, bus.in_nbytes) : bus.in_data;
      end else if (state_q == ST_PAD && !wptr_q[4]) begin
         wr_en = 1'b1;
         if (mark_q) begin
            wr_data = PAD_MARKER;
         end else if (fit_q && wptr_q == LEN_HI_IDX) begin
            wr_data = len_q[LEN_W-1:WORD_W];
         end else if (fit_q && wptr_q == LEN_LO_IDX) begin
            wr_data = len_q[WORD_W-1:0];
         end
      end
   end

   sha256_block_buffer u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wptr_q[3:0]),
      .wr_data (wr_data),
      .rd_idx  (scnt_q[3:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_FILL;
         tail_q        <= TAIL_NONE;
         wptr_q        <= '0;
         scnt_q        <= '0;
         len_q         <= '0;
         first_q       <= 1'b1;
         final_q       <= 1'b0;
         mark_q        <= 1'b0;
         fit_q         <= 1'b0;
         wait_q        <= 1'b0;
         in_ready_q    <= 1'b0;
         we_q          <= 1'b0;
         first_block_q <= 1'b0;
         last_block_q  <= 1'b0;
         data_q        <= '0;
      end else begin
         in_ready_q <= 1'b0;
         case (state_q)
            ST_FILL, ST_PAD: begin
               if (wptr_q[4]) begin
                  // Block complete: word 0 leaves on the same edge the burst is
                  // committed, so the core sees it one cycle after busy drops.
                  if (!bus.busy) begin
                     state_q       <= ST_SEND;
                     data_q        <= rd_data;
                     we_q          <= 1'b1;
                     first_block_q <= first_q;
                     last_block_q  <= final_q;
                     first_q       <= 1'b0;
                     scnt_q        <= 5'd1;
                  end
               end else if (state_q == ST_FILL) begin
                  in_ready_q <= 1'b1;
                  if (accept) begin
                     wptr_q <= wptr_q + 5'd1;
                     len_q  <= len_q + LEN_W'({word_nbytes, 3'b000});
                     if (bus.in_last) begin
                        in_ready_q <= 1'b0;
                        if (word_nbytes == 3'd4) begin
                           // Marker goes into the slot after this word.
                           if (wptr_q == LAST_IDX) begin
                              tail_q <= TAIL_MARK;
                           end else begin
                              mark_q  <= 1'b1;
                              state_q <= ST_PAD;
                           end
                        end else begin
                           fit_q <= (wptr_q < LEN_HI_IDX);
                           if (wptr_q == LAST_IDX) begin
                              tail_q <= TAIL_ZERO;
                           end else begin
                              state_q <= ST_PAD;
                           end
                        end
                     end else if (wptr_q == LAST_IDX) begin
                        in_ready_q <= 1'b0;
                     end
                  end
               end else begin
                  wptr_q <= wptr_q + 5'd1;
                  if (mark_q) begin
                     mark_q <= 1'b0;
                     fit_q  <= (wptr_q < LEN_HI_IDX);
                  end
                  if (wptr_q == LAST_IDX) begin
                     if (mark_q || !fit_q) begin
                        tail_q <= TAIL_ZERO;
                     end else begin
                        final_q <= 1'b1;
                     end
                  end
               end
            end

            ST_SEND: begin
               first_block_q <= 1'b0;
               last_block_q  <= 1'b0;
               if (scnt_q[4]) begin
                  we_q    <= 1'b0;
                  data_q  <= '0;
                  scnt_q  <= '0;
                  wait_q  <= 1'b0;
                  state_q <= ST_WAIT;
               end else begin
                  data_q <= rd_data;
                  we_q   <= 1'b1;
                  scnt_q <= scnt_q + 5'd1;
               end
            end

            ST_WAIT: begin
               // First cycle is unconditional: the core's busy may still be low.
               if (!wait_q) begin
                  wait_q <= 1'b1;
               end else if (final_q) begin
                  if (!bus.busy) begin
                     state_q    <= ST_FILL;
                     wptr_q     <= '0;
                     len_q      <= '0;
                     first_q    <= 1'b1;
                     final_q    <= 1'b0;
                     in_ready_q <= 1'b1;
                  end
               end else if (tail_q != TAIL_NONE) begin
                  // Padding-only blocks are built while the core works; the
                  // burst itself still waits for busy to clear.
                  state_q <= ST_PAD;
                  wptr_q  <= '0;
                  mark_q  <= (tail_q == TAIL_MARK);
                  fit_q   <= 1'b1;
                  tail_q  <= TAIL_NONE;
               end else if (!bus.busy) begin
                  state_q    <= ST_FILL;
                  wptr_q     <= '0;
                  in_ready_q <= 1'b1;
               end
            end

            default: state_q <= ST_FILL;
         endcase
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.data         = data_q;
   assign bus.write_enable = we_q;
   assign bus.first_block  = first_block_q;
   assign bus.last_block   = last_block_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - scoreboard bench for sha256_msg_padder
module tb_sha256_msg_padder;

   typedef struct packed {
      logic [31:0] data;
      logic        first;
      logic        last;
   } exp_word_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   sha256_msg_padder_if bus();

   sha256_msg_padder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_word_t  exp_q[$];
   logic [7:0] msg_b[$];
   exp_word_t  mon_e;
   int n_vec      = 0;
   int n_bad      = 0;
   int words_seen = 0;
   int run_len    = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-level reference padding of msg_b, pushed as expected burst words.
   task automatic push_expected();
      logic [7:0]  pb[$];
      logic [63:0] bits;
      int          nblk;
      bits = 64'(msg_b.size()) * 64'd8;
      pb = msg_b;
      pb.push_back(8'h80);
      while ((pb.size() % 64) != 56) pb.push_back(8'h00);
      for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
      nblk = pb.size() / 64;
      for (int w = 0; w < pb.size() / 4; w++) begin
         exp_word_t e;
         e.data  = {pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]};
         e.first = (w == 0);
         e.last  = (w == (nblk - 1) * 16);
         exp_q.push_back(e);
      end
   endtask

   task automatic set_msg_seq(input int len, input logic [7:0] seed);
      msg_b.delete();
      for (int i = 0; i < len; i++) msg_b.push_back(seed + 8'(i * 7));
   endtask

   // Unused low bytes of the final word carry junk the padder must mask off.
   task automatic drive_msg(input bit toggle);
      int          len;
      int          nw;
      int          nb;
      int          guard;
      bit          done;
      bit          phase;
      logic        rdy;
      logic [31:0] w;
      len   = msg_b.size();
      nw    = (len == 0) ? 1 : (len + 3) / 4;
      phase = 1'b0;
      for (int i = 0; i < nw; i++) begin
         nb = len - 4 * i;
         if (nb > 4) nb = 4;
         w = 32'hA5A5_A5A5;
         for (int b = 0; b < nb; b++) w[31-8*b -: 8] = msg_b[4*i+b];
         done  = 1'b0;
         guard = 0;
         while (!done && guard < 1000) begin
            phase = toggle ? ~phase : 1'b1;
            bus.in_valid  = phase;
            bus.in_data   = w;
            bus.in_last   = (i == nw - 1);
            bus.in_nbytes = 3'(nb);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (phase && rdy) done = 1'b1;
            guard++;
         end
         if (!done) check_eq("accept_timeout", 64'(done), 64'd1);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check_eq("drain", 64'(exp_q.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         run_len = 0;
      end else if (bus.write_enable) begin
         run_len++;
         words_seen++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_we", 64'(bus.write_enable), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("data", 64'(bus.data), 64'(mon_e.data));
            check_eq("flags", 64'({bus.first_block, bus.last_block}),
                     64'({mon_e.first, mon_e.last}));
         end
      end else if (run_len != 0) begin
         check_eq("burst_len", 64'(run_len), 64'd16);
         run_len = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
      $fatal(1);
   end

   initial begin
      int base;
      int guard;
      int leak;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.in_nbytes = '0;
      bus.busy      = 1'b0;

      // Reset values and in_ready rising one edge after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_outputs", 64'({bus.write_enable, bus.first_block, bus.last_block,
                                   bus.in_ready, bus.data}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("in_ready_hold", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      check_eq("in_ready_rise", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // "abc"
      msg_b.delete();
      msg_b.push_back(8'h61);
      msg_b.push_back(8'h62);
      msg_b.push_back(8'h63);
      push_expected();
      drive_msg(1'b0);
      wait_drain();

      // Empty message.
      msg_b.delete();
      push_expected();
      drive_msg(1'b0);
      wait_drain();

      // 56 bytes: length spills into a second block.
      set_msg_seq(56, 8'h11);
      push_expected();
      drive_msg(1'b0);
      wait_drain();

      // 55 bytes: marker in word 13, length fits in the same block.
      set_msg_seq(55, 8'h2B);
      push_expected();
      drive_msg(1'b0);
      wait_drain();

      // 62 bytes: marker lands in word 15.
      set_msg_seq(62, 8'h77);
      push_expected();
      drive_msg(1'b0);
      wait_drain();

      // 64 bytes with busy held high for 70 cycles after block 1.
      set_msg_seq(64, 8'h40);
      push_expected();
      base = words_seen;
      drive_msg(1'b0);
      guard = 0;
      while (words_seen < base + 16 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (words_seen < base + 16) check_eq("block1_timeout", 64'(words_seen - base), 64'd16);
      #1;
      bus.busy = 1'b1;
      leak = 0;
      repeat (70) begin
         @(negedge clk);
         if (bus.in_ready || bus.write_enable) leak++;
      end
      check_eq("busy_hold", 64'(leak), 64'd0);
      @(posedge clk);
      #1;
      bus.busy = 1'b0;
      @(negedge clk);
      check_eq("we_at_busy_fall", 64'(bus.write_enable), 64'd0);
      @(negedge clk);
      check_eq("we_after_busy_fall", 64'(bus.write_enable), 64'd1);
      @(posedge clk);
      #1;
      wait_drain();

      // 80 bytes with in_valid toggling every other cycle.
      set_msg_seq(80, 8'h9C);
      push_expected();
      drive_msg(1'b1);
      wait_drain();

      // Reset while burst word 7 is on the output.
      set_msg_seq(10, 8'h33);
      push_expected();
      base = words_seen;
      drive_msg(1'b0);
      guard = 0;
      while (words_seen < base + 7 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (words_seen < base + 7) check_eq("word7_timeout", 64'(words_seen - base), 64'd7);
      #2;
      check_eq("we_word7", 64'(bus.write_enable), 64'd1);
      if (exp_q.size() != 0) check_eq("word7_data", 64'(bus.data), 64'(exp_q[0].data));
      reset = 1'b1;
      #1;
      check_eq("we_async_drop", 64'(bus.write_enable), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Next message must be framed as a fresh first block with length from zero.
      msg_b.delete();
      msg_b.push_back(8'h61);
      msg_b.push_back(8'h62);
      msg_b.push_back(8'h63);
      push_expected();
      drive_msg(1'b0);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
